// File: rtl/dc_tag_index_steer.sv
// dc_tag_index_steer: steers D-cache tag requests to even/odd bank FIFOs by set-index parity.
// Rev 1.0 - initial release
`default_nettype none

module dc_tag_index_steer #(
   parameter int Width    = 24,
   parameter int REQ_BITS = 7,
   parameter int IDX_BIT  = 10,
   parameter int DEPTH    = 2,
   parameter int SEQ_BITS = 3
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      req_valid,
   output logic                      req_retry,
   input  logic [REQ_BITS-1:0]       req_type,
   input  logic                      req_write,
   input  logic [Width-1:0]          req_data,
   input  logic [Width-1:0]          req_value,
   output logic                      even_valid,
   input  logic                      even_retry,
   output logic [REQ_BITS-1:0]       even_type,
   output logic                      even_write,
   output logic [Width-1:0]          even_data,
   output logic [Width-1:0]          even_value,
   output logic [SEQ_BITS-1:0]       even_seq,
   output logic                      odd_valid,
   input  logic                      odd_retry,
   output logic [REQ_BITS-1:0]       odd_type,
   output logic                      odd_write,
   output logic [Width-1:0]          odd_data,
   output logic [Width-1:0]          odd_value,
   output logic [SEQ_BITS-1:0]       odd_seq,
   output logic [$clog2(DEPTH):0]    even_cnt,
   output logic [$clog2(DEPTH):0]    odd_cnt
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int EW = REQ_BITS + 1 + 2 * Width + SEQ_BITS;

   logic [SEQ_BITS-1:0] seq_q;
   logic [SEQ_BITS-1:0] seq_d;
   logic [EW-1:0]       req_entry;
   logic                tgt;
   logic                accept;
   logic [1:0]          bank_full;
   logic [1:0]          bank_valid;
   logic [1:0]          bank_push;
   logic [1:0]          bank_pop;
   logic [EW-1:0]       head [2];
   logic [CW-1:0]       cnt  [2];

   assign tgt       = req_data[IDX_BIT];
   // A full bank always retries, even if it pops this cycle: no same-cycle bypass.
   assign req_retry = req_valid & bank_full[tgt];
   assign accept    = req_valid & ~bank_full[tgt];
   assign req_entry = {req_type, req_write, req_data, req_value, seq_q};

   assign bank_push = {accept & tgt, accept & ~tgt};
   assign bank_pop  = {bank_valid[1] & ~odd_retry, bank_valid[0] & ~even_retry};

   always_comb begin
      seq_d = seq_q + SEQ_BITS'(accept);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         seq_q <= '0;
      end else begin
         seq_q <= seq_d;
      end
   end

   generate
      for (genvar b = 0; b < 2; b++) begin : g_bank
         logic [EW-1:0] mem_q [DEPTH];
         logic [EW-1:0] mem_d [DEPTH];
         logic [PW-1:0] wr_q, wr_d;
         logic [PW-1:0] rd_q, rd_d;
         logic [CW-1:0] cnt_q, cnt_d;

         always_comb begin
            mem_d = mem_q;
            wr_d  = wr_q;
            rd_d  = rd_q;
            if (bank_push[b]) begin
               mem_d[wr_q] = req_entry;
               wr_d        = wr_q + PW'(1);
            end
            if (bank_pop[b]) begin
               rd_d = rd_q + PW'(1);
            end
            cnt_d = cnt_q + CW'(bank_push[b]) - CW'(bank_pop[b]);
         end

         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               for (int i = 0; i < DEPTH; i++) begin
                  mem_q[i] <= '0;
               end
               wr_q  <= '0;
               rd_q  <= '0;
               cnt_q <= '0;
            end else begin
               mem_q <= mem_d;
               wr_q  <= wr_d;
               rd_q  <= rd_d;
               cnt_q <= cnt_d;
            end
         end

         assign bank_full[b]  = (cnt_q == CW'(DEPTH));
         assign bank_valid[b] = (cnt_q != '0);
         assign head[b]       = mem_q[rd_q];
         assign cnt[b]        = cnt_q;
      end
   endgenerate

   assign even_valid = bank_valid[0];
   assign odd_valid  = bank_valid[1];
   assign even_cnt   = cnt[0];
   assign odd_cnt    = cnt[1];
   assign {even_type, even_write, even_data, even_value, even_seq} = head[0];
   assign {odd_type,  odd_write,  odd_data,  odd_value,  odd_seq}  = head[1];

endmodule

`default_nettype wire

// File: tb/tb_dc_tag_index_steer.sv
// tb_dc_tag_index_steer: directed and random checks of dc_tag_index_steer against a queue model.
// Rev 1.0 - initial release
`default_nettype none

module tb_dc_tag_index_steer;

   localparam int W  = 24;
   localparam int RB = 7;
   localparam int IB = 10;
   localparam int D  = 2;
   localparam int SB = 3;
   localparam int EW = RB + 1 + 2 * W + SB;

   logic clk = 1'b0;
   logic reset;
   logic req_valid, req_retry, req_write;
   logic [RB-1:0] req_type;
   logic [W-1:0]  req_data, req_value;
   logic even_valid, even_retry, even_write;
   logic [RB-1:0] even_type;
   logic [W-1:0]  even_data, even_value;
   logic [SB-1:0] even_seq;
   logic odd_valid, odd_retry, odd_write;
   logic [RB-1:0] odd_type;
   logic [W-1:0]  odd_data, odd_value;
   logic [SB-1:0] odd_seq;
   logic [1:0]    even_cnt, odd_cnt;

   dc_tag_index_steer dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_retry(req_retry), .req_type(req_type),
      .req_write(req_write), .req_data(req_data), .req_value(req_value),
      .even_valid(even_valid), .even_retry(even_retry), .even_type(even_type),
      .even_write(even_write), .even_data(even_data), .even_value(even_value),
      .even_seq(even_seq),
      .odd_valid(odd_valid), .odd_retry(odd_retry), .odd_type(odd_type),
      .odd_write(odd_write), .odd_data(odd_data), .odd_value(odd_value),
      .odd_seq(odd_seq),
      .even_cnt(even_cnt), .odd_cnt(odd_cnt)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int mseq     = 0;
   logic [EW-1:0] q_even[$];
   logic [EW-1:0] q_odd[$];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic set_req(input logic v, input logic [W-1:0] d);
      req_valid = v;
      req_data  = d;
      req_type  = RB'($urandom);
      req_write = 1'($urandom);
      req_value = W'($urandom);
   endtask

   // Called just after a falling edge with inputs driven; checks, updates model, advances a cycle.
   task automatic step();
      bit fe, fo, acc, pe, po;
      logic [EW-1:0] e;
      #1;
      fe = (q_even.size() == D);
      fo = (q_odd.size() == D);
      chk("req_retry", req_retry, req_valid && (req_data[IB] ? fo : fe));
      chk("even_valid", even_valid, q_even.size() != 0);
      chk("odd_valid", odd_valid, q_odd.size() != 0);
      chk("even_cnt", even_cnt, q_even.size());
      chk("odd_cnt", odd_cnt, q_odd.size());
      if (q_even.size() != 0)
         chk("even_head", {even_type, even_write, even_data, even_value, even_seq}, q_even[0]);
      if (q_odd.size() != 0)
         chk("odd_head", {odd_type, odd_write, odd_data, odd_value, odd_seq}, q_odd[0]);
      pe  = (q_even.size() != 0) && !even_retry;
      po  = (q_odd.size() != 0) && !odd_retry;
      acc = req_valid && !(req_data[IB] ? fo : fe);
      if (pe) void'(q_even.pop_front());
      if (po) void'(q_odd.pop_front());
      if (acc) begin
         e = {req_type, req_write, req_data, req_value, SB'(mseq)};
         if (req_data[IB]) q_odd.push_back(e);
         else q_even.push_back(e);
         mseq = (mseq + 1) % (1 << SB);
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_valids"}, {even_valid, odd_valid}, 0);
      chk({tag, "_cnts"}, {even_cnt, odd_cnt}, 0);
      chk({tag, "_even_head"}, {even_type, even_write, even_data, even_value, even_seq}, 0);
      chk({tag, "_odd_head"}, {odd_type, odd_write, odd_data, odd_value, odd_seq}, 0);
   endtask

   task automatic drain();
      set_req(1'b0, '0);
      even_retry = 1'b0;
      odd_retry  = 1'b0;
      for (int i = 0; i < 2 * D + 2; i++) step();
      chk("drain_empty", q_even.size() + q_odd.size(), 0);
   endtask

   initial begin
      reset = 1'b0;
      set_req(1'b0, '0);
      even_retry = 1'b0;
      odd_retry  = 1'b0;
      #12;
      check_all_zero("por");
      @(negedge clk);
      reset = 1'b1;

      // Steering and one-cycle latency
      set_req(1'b1, 24'h000400);
      step();
      chk("t2_odd_valid", odd_valid, 1);
      chk("t2_odd_seq", odd_seq, 0);
      set_req(1'b1, 24'h000000);
      odd_retry = 1'b1;
      step();
      chk("t2_even_valid", even_valid, 1);
      chk("t2_even_seq", even_seq, 1);
      drain();

      // Backpressure on the even bank, odd still flows
      even_retry = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         set_req(1'b1, W'(i));
         if (i == 3) begin
            #1;
            chk("t3_retry_third", req_retry, 1);
         end
         step();
      end
      chk("t3_even_cnt", even_cnt, 2);
      chk("t3_even_head", even_data, 24'h000001);
      set_req(1'b1, 24'h000405);
      #1;
      chk("t3_odd_accept", req_retry, 0);
      step();
      chk("t3_odd_valid", odd_valid, 1);

      // Full bank pops while a new request targets it: no bypass
      even_retry = 1'b0;
      set_req(1'b1, 24'h000007);
      #1;
      chk("t4_retry_full", req_retry, 1);
      step();
      chk("t4_even_cnt", even_cnt, 1);
      #1;
      chk("t4_accept_next", req_retry, 0);
      step();
      drain();

      // Asynchronous reset with both banks full
      even_retry = 1'b1;
      odd_retry  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         set_req(1'b1, W'($urandom) & ~(W'(1) << IB) | (W'(i & 1) << IB));
         step();
      end
      chk("t1_full", {even_cnt, odd_cnt}, {2'd2, 2'd2});
      set_req(1'b0, '0);
      #2;
      reset = 1'b0;
      #1;
      check_all_zero("t1_async");
      q_even.delete();
      q_odd.delete();
      mseq = 0;
      @(negedge clk);
      reset = 1'b1;
      even_retry = 1'b0;
      odd_retry  = 1'b0;

      // Sequence number wrap
      for (int i = 0; i < 10; i++) begin
         set_req(1'b1, W'($urandom) & ~(W'(1) << IB) | (W'(i & 1) << IB));
         step();
         chk("t5_seq", (i & 1) ? odd_seq : even_seq, i % 8);
      end
      drain();

      // Random traffic
      for (int i = 0; i < 10000; i++) begin
         set_req(1'($urandom), W'($urandom));
         even_retry = ($urandom_range(0, 3) == 0);
         odd_retry  = ($urandom_range(0, 2) == 0);
         step();
      end
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
